// File: rtl/fetch_pkg.sv
// Shared types and limits for the fetch sequencer slice.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned MEM_LAT_MAX    = 7;
  localparam int unsigned LAT_W          = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PC,
    PC_TO_MAR,
    MEM_READ,
    LATCH,
    ISSUE
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/strobe bundle between the fetch sequencer and the fetch-stage wrapper.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned CNT_W  = 16
);

  logic              start;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [ADDR_W-1:0] pc_addr_out;
  logic              ProgramCounter_rd;
  logic              ProgramCounter_wr;
  logic              MAR_rd;
  logic              MAR_wr;
  logic              ProgramMemory_rd;
  logic              ProgramMemory_wr;
  logic              MDR_rd;
  logic              MDR_wr;
  logic              IR_rd;
  logic              IR_wr;
  logic              busy;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    input  start, redirect_valid, redirect_addr, fetch_ready,
    output fetch_valid, pc_addr_out,
           ProgramCounter_rd, ProgramCounter_wr, MAR_rd, MAR_wr,
           ProgramMemory_rd, ProgramMemory_wr, MDR_rd, MDR_wr,
           IR_rd, IR_wr, busy, fetch_count
  );

  modport slave (
    output start, redirect_valid, redirect_addr, fetch_ready,
    input  fetch_valid, pc_addr_out,
           ProgramCounter_rd, ProgramCounter_wr, MAR_rd, MAR_wr,
           ProgramMemory_rd, ProgramMemory_wr, MDR_rd, MDR_wr,
           IR_rd, IR_wr, busy, fetch_count
  );

endinterface

// File: rtl/fetch_redirect_latch.sv
// Holds the pending branch target; the newest request wins, and a request in
// the same cycle as consumption survives as the next pending target.
module fetch_redirect_latch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              consume_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] target_o
);

  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] target_q, target_d;

  // Capture beats consume so a redirect landing in LOAD_PC is not lost.
  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    if (redirect_valid_i) begin
      pending_d = 1'b1;
      target_d  = redirect_addr_i;
    end else if (consume_i) begin
      pending_d = 1'b0;
    end
  end

  // Pending flag and target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      target_q  <= '0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  assign pending_o = pending_q;
  assign target_o  = target_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: PC -> MAR -> program memory -> MDR/IR -> decode handshake,
// with branch redirects that squash the in-flight fetch.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  fetch_state_e      state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pending;
  logic              consume;
  logic              redirect_any;
  logic [ADDR_W-1:0] target;

  fetch_redirect_latch #(.ADDR_W(ADDR_W)) u_redirect (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_addr_i  (bus.redirect_addr),
    .consume_i        (consume),
    .pending_o        (pending),
    .target_o         (target)
  );

  // A redirect arriving this cycle counts as pending for the branch decision.
  assign redirect_any = pending | bus.redirect_valid;

  // Next-state, memory-latency countdown and accepted-fetch counter.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    count_d = count_q;
    consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_any)   state_d = LOAD_PC;
        else if (bus.start) state_d = PC_TO_MAR;
      end
      LOAD_PC: begin
        consume = 1'b1;
        state_d = bus.start ? PC_TO_MAR : IDLE;
      end
      PC_TO_MAR: begin
        lat_d   = LAT_LAST;
        state_d = MEM_READ;
      end
      MEM_READ: begin
        if (lat_q == '0) state_d = LATCH;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      LATCH: begin
        state_d = redirect_any ? LOAD_PC : ISSUE;
      end
      ISSUE: begin
        if (bus.fetch_ready) begin
          count_d = count_q + CNT_W'(1);
          if (redirect_any)   state_d = LOAD_PC;
          else if (bus.start) state_d = PC_TO_MAR;
          else                state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter and fetch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      count_q <= count_d;
    end
  end

  // Strobes decoded from the state register only.
  always_comb begin
    bus.fetch_valid       = 1'b0;
    bus.pc_addr_out       = '0;
    bus.ProgramCounter_rd = 1'b0;
    bus.ProgramCounter_wr = 1'b0;
    bus.MAR_rd            = 1'b0;
    bus.MAR_wr            = 1'b0;
    bus.ProgramMemory_rd  = 1'b0;
    bus.ProgramMemory_wr  = 1'b0;
    bus.MDR_rd            = 1'b0;
    bus.MDR_wr            = 1'b0;
    bus.IR_rd             = 1'b0;
    bus.IR_wr             = 1'b0;
    bus.busy              = (state_q != IDLE);
    bus.fetch_count       = count_q;
    unique case (state_q)
      LOAD_PC: begin
        bus.ProgramCounter_wr = 1'b1;
        bus.pc_addr_out       = target;
      end
      PC_TO_MAR: begin
        bus.ProgramCounter_rd = 1'b1;
        bus.MAR_wr            = 1'b1;
      end
      MEM_READ: begin
        bus.MAR_rd           = 1'b1;
        bus.ProgramMemory_rd = 1'b1;
      end
      LATCH: begin
        bus.ProgramMemory_rd = 1'b1;
        bus.MDR_wr           = 1'b1;
        bus.IR_wr            = 1'b1;
      end
      ISSUE: begin
        bus.IR_rd       = 1'b1;
        bus.MDR_rd      = 1'b1;
        bus.fetch_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected per-cycle output snapshots are
// queued as stimulus is applied and compared on the falling clock edge.
module tb_fetch_sequencer;

  // Snapshot layout: {busy, fetch_valid, PC_rd, PC_wr, MAR_rd, MAR_wr,
  //                   PM_rd, PM_wr, MDR_rd, MDR_wr, IR_rd, IR_wr, pc[4:0], count[15:0]}
  localparam logic [11:0] V_IDLE = 12'b0000_0000_0000;
  localparam logic [11:0] V_LOAD = 12'b1001_0000_0000;
  localparam logic [11:0] V_P2M  = 12'b1010_0100_0000;
  localparam logic [11:0] V_MEM  = 12'b1000_1010_0000;
  localparam logic [11:0] V_LAT  = 12'b1000_0010_0101;
  localparam logic [11:0] V_ISS  = 12'b1100_0000_1010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] sb[$];

  fetch_sequencer_if #(.ADDR_W(5), .CNT_W(16)) if1 ();
  fetch_sequencer_if #(.ADDR_W(5), .CNT_W(16)) if3 ();

  fetch_sequencer #(.ADDR_W(5), .MEM_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  fetch_sequencer #(.ADDR_W(5), .MEM_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [32:0] obs1();
    return {if1.busy, if1.fetch_valid, if1.ProgramCounter_rd, if1.ProgramCounter_wr,
            if1.MAR_rd, if1.MAR_wr, if1.ProgramMemory_rd, if1.ProgramMemory_wr,
            if1.MDR_rd, if1.MDR_wr, if1.IR_rd, if1.IR_wr, if1.pc_addr_out, if1.fetch_count};
  endfunction

  function automatic logic [32:0] obs3();
    return {if3.busy, if3.fetch_valid, if3.ProgramCounter_rd, if3.ProgramCounter_wr,
            if3.MAR_rd, if3.MAR_wr, if3.ProgramMemory_rd, if3.ProgramMemory_wr,
            if3.MDR_rd, if3.MDR_wr, if3.IR_rd, if3.IR_wr, if3.pc_addr_out, if3.fetch_count};
  endfunction

  function automatic logic [32:0] ex(input logic [11:0] v, input logic [4:0] pc, input int c);
    return {v, pc, 16'(c)};
  endfunction

  task automatic test_reset();
    logic [32:0] got;
    logic [32:0] e;
    if1.start = 0; if1.fetch_ready = 1; if1.redirect_valid = 0; if1.redirect_addr = '0;
    if3.start = 0; if3.fetch_ready = 1; if3.redirect_valid = 0; if3.redirect_addr = '0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = ex(V_IDLE, 5'h00, 0);
      got = (k == 0) ? obs1() : obs3();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_hold dut%0d: got %b expected %b", k, got, e);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = ex(V_IDLE, 5'h00, 0);
      got = (k == 0) ? obs1() : obs3();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_basic();
    logic [32:0] got;
    logic [32:0] e;
    if1.start = 1; if1.fetch_ready = 1;
    for (int k = 0; k < 13; k++) begin
      case (k % 4)
        0: sb.push_back(ex(V_P2M, 5'h00, k / 4));
        1: sb.push_back(ex(V_MEM, 5'h00, k / 4));
        2: sb.push_back(ex(V_LAT, 5'h00, k / 4));
        default: sb.push_back(ex(V_ISS, 5'h00, k / 4));
      endcase
    end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL basic sample %0d: got vec=%b pc=%h cnt=%0d expected vec=%b pc=%h cnt=%0d",
                 i, got[32:21], got[20:16], got[15:0], e[32:21], e[20:16], e[15:0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [32:0] got;
    logic [32:0] e;
    if1.fetch_ready = 0;
    sb.push_back(ex(V_MEM, 5'h00, 3));
    sb.push_back(ex(V_LAT, 5'h00, 3));
    repeat (5) sb.push_back(ex(V_ISS, 5'h00, 3));
    sb.push_back(ex(V_P2M, 5'h00, 4));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stall sample %0d: got vec=%b pc=%h cnt=%0d expected vec=%b pc=%h cnt=%0d",
                 i, got[32:21], got[20:16], got[15:0], e[32:21], e[20:16], e[15:0]);
      end
      if (i == 6) if1.fetch_ready = 1;
    end
  endtask

  task automatic test_start_drop();
    logic [32:0] got;
    logic [32:0] e;
    if1.start = 0;
    sb.push_back(ex(V_MEM, 5'h00, 4));
    sb.push_back(ex(V_LAT, 5'h00, 4));
    sb.push_back(ex(V_ISS, 5'h00, 4));
    sb.push_back(ex(V_IDLE, 5'h00, 5));
    sb.push_back(ex(V_IDLE, 5'h00, 5));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL start_drop sample %0d: got vec=%b pc=%h cnt=%0d expected vec=%b pc=%h cnt=%0d",
                 i, got[32:21], got[20:16], got[15:0], e[32:21], e[20:16], e[15:0]);
      end
    end
  endtask

  task automatic test_redirect_squash();
    logic [32:0] got;
    logic [32:0] e;
    if1.start = 1;
    sb.push_back(ex(V_P2M, 5'h00, 5));
    sb.push_back(ex(V_MEM, 5'h00, 5));
    sb.push_back(ex(V_LAT, 5'h00, 5));
    sb.push_back(ex(V_LOAD, 5'h1A, 5));
    sb.push_back(ex(V_P2M, 5'h00, 5));
    sb.push_back(ex(V_MEM, 5'h00, 5));
    sb.push_back(ex(V_LAT, 5'h00, 5));
    sb.push_back(ex(V_ISS, 5'h00, 5));
    sb.push_back(ex(V_P2M, 5'h00, 6));
    sb.push_back(ex(V_MEM, 5'h00, 6));
    sb.push_back(ex(V_LAT, 5'h00, 6));
    sb.push_back(ex(V_ISS, 5'h00, 6));
    sb.push_back(ex(V_IDLE, 5'h00, 7));
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL redirect_squash sample %0d: got vec=%b pc=%h cnt=%0d expected vec=%b pc=%h cnt=%0d",
                 i, got[32:21], got[20:16], got[15:0], e[32:21], e[20:16], e[15:0]);
      end
      if (i == 1) begin if1.redirect_valid = 1; if1.redirect_addr = 5'h1A; end
      if (i == 2) if1.redirect_valid = 0;
      if (i == 8) if1.start = 0;
    end
  endtask

  task automatic test_redirect_newest();
    logic [32:0] got;
    logic [32:0] e;
    if1.start = 1;
    sb.push_back(ex(V_P2M, 5'h00, 7));
    sb.push_back(ex(V_MEM, 5'h00, 7));
    sb.push_back(ex(V_LAT, 5'h00, 7));
    sb.push_back(ex(V_LOAD, 5'h07, 7));
    sb.push_back(ex(V_IDLE, 5'h00, 7));
    sb.push_back(ex(V_IDLE, 5'h00, 7));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL redirect_newest sample %0d: got vec=%b pc=%h cnt=%0d expected vec=%b pc=%h cnt=%0d",
                 i, got[32:21], got[20:16], got[15:0], e[32:21], e[20:16], e[15:0]);
      end
      if (i == 0) begin if1.redirect_valid = 1; if1.redirect_addr = 5'h03; end
      if (i == 1) if1.redirect_addr = 5'h07;
      if (i == 2) begin if1.redirect_valid = 0; if1.start = 0; end
    end
  endtask

  task automatic test_redirect_issue();
    logic [32:0] got;
    logic [32:0] e;
    if1.start = 1; if1.fetch_ready = 0;
    sb.push_back(ex(V_P2M, 5'h00, 7));
    sb.push_back(ex(V_MEM, 5'h00, 7));
    sb.push_back(ex(V_LAT, 5'h00, 7));
    sb.push_back(ex(V_ISS, 5'h00, 7));
    sb.push_back(ex(V_ISS, 5'h00, 7));
    sb.push_back(ex(V_LOAD, 5'h11, 8));
    sb.push_back(ex(V_IDLE, 5'h00, 8));
    sb.push_back(ex(V_LOAD, 5'h05, 8));
    sb.push_back(ex(V_IDLE, 5'h00, 8));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL redirect_issue sample %0d: got vec=%b pc=%h cnt=%0d expected vec=%b pc=%h cnt=%0d",
                 i, got[32:21], got[20:16], got[15:0], e[32:21], e[20:16], e[15:0]);
      end
      if (i == 3) begin if1.redirect_valid = 1; if1.redirect_addr = 5'h11; end
      if (i == 4) begin if1.redirect_valid = 0; if1.fetch_ready = 1; end
      if (i == 5) begin if1.redirect_valid = 1; if1.redirect_addr = 5'h05; if1.start = 0; end
      if (i == 6) if1.redirect_valid = 0;
    end
  endtask

  task automatic test_mem_lat3();
    logic [32:0] got;
    logic [32:0] e;
    if3.start = 1; if3.fetch_ready = 1;
    for (int f = 0; f < 3; f++) begin
      sb.push_back(ex(V_P2M, 5'h00, f));
      repeat (3) sb.push_back(ex(V_MEM, 5'h00, f));
      sb.push_back(ex(V_LAT, 5'h00, f));
      sb.push_back(ex(V_ISS, 5'h00, f));
    end
    sb.push_back(ex(V_IDLE, 5'h00, 3));
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs3();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mem_lat3 sample %0d: got vec=%b pc=%h cnt=%0d expected vec=%b pc=%h cnt=%0d",
                 i, got[32:21], got[20:16], got[15:0], e[32:21], e[20:16], e[15:0]);
      end
      if (i == 12) if3.start = 0;
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] got;
    logic [32:0] e;
    if1.start = 1;
    sb.push_back(ex(V_P2M, 5'h00, 8));
    sb.push_back(ex(V_MEM, 5'h00, 8));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_pre sample %0d: got %b expected %b", i, got, e);
      end
      if (i == 0) begin if1.redirect_valid = 1; if1.redirect_addr = 5'h1F; end
      if (i == 1) if1.redirect_valid = 0;
    end
    #2 rst_n = 1'b0;
    if1.start = 0;
    #1;
    sb.push_back(ex(V_IDLE, 5'h00, 0));
    e = sb.pop_front(); got = obs1();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", got, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) sb.push_back(ex(V_IDLE, 5'h00, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = sb.pop_front(); got = obs1();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_post sample %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_drop();
    test_redirect_squash();
    test_redirect_newest();
    test_redirect_issue();
    test_mem_lat3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
